rc_sram_pipe: RTL and testbench

//  Cache-data SRAM controller stage fed by the issue unit's d_rc request port.

---
 rtl/rc_sram_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_rc_sram_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_sram_pipe.sv
// Cache-data SRAM controller stage: takes one d_rc request per cycle, performs the single
// data-SRAM access (merging write-buffer/refill data) and returns load data in order.
module rc_sram_pipe #(
   parameter int SET_W     = 8,
   parameter int WAY_W     = 2,
   parameter int ROB_W     = 4,
   parameter int WBUF_W    = 3,
   parameter int DATA_W    = 128,
   parameter int SRAM_LAT  = 2,
   parameter int RSP_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rc_valid,
   output logic                     rc_ready,
   input  logic [2:0]               rc_channel_1hot_id,
   input  logic [ROB_W-1:0]         rc_rob_id,
   input  logic [2:0]               rc_op,
   input  logic [SET_W-1:0]         rc_set,
   input  logic [WAY_W-1:0]         rc_way,
   input  logic [WBUF_W-1:0]        rc_wbuf_id,
   input  logic [DATA_W-1:0]        rc_refill_data,
   output logic                     wbuf_rd_en,
   output logic [WBUF_W-1:0]        wbuf_rd_id,
   input  logic [DATA_W-1:0]        wbuf_rd_data,
   input  logic [DATA_W/8-1:0]      wbuf_rd_be,
   output logic                     wbuf_free_valid,
   output logic [WBUF_W-1:0]        wbuf_free_id,
   output logic                     sram_en,
   output logic                     sram_we,
   output logic [WAY_W+SET_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]        sram_wdata,
   input  logic [DATA_W-1:0]        sram_rdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [2:0]               rsp_channel_1hot_id,
   output logic [ROB_W-1:0]         rsp_rob_id,
   output logic [DATA_W-1:0]        rsp_data
);

   localparam int BE_W  = DATA_W / 8;
   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int OCC_W = $clog2(RSP_DEPTH + 1);

   localparam logic [2:0] CACHE_OP_LOAD         = 3'd0;
   localparam logic [2:0] CACHE_OP_STORE        = 3'd1;
   localparam logic [2:0] CACHE_OP_LOAD_REFILL  = 3'd2;
   localparam logic [2:0] CACHE_OP_STORE_REFILL = 3'd3;
   localparam logic [2:0] CACHE_OP_REFILL       = 3'd4;

   function automatic logic op_is_store(input logic [2:0] op);
      return (op == CACHE_OP_STORE) || (op == CACHE_OP_STORE_REFILL);
   endfunction

   function automatic logic op_is_rsp(input logic [2:0] op);
      return (op == CACHE_OP_LOAD) || (op == CACHE_OP_LOAD_REFILL);
   endfunction

   function automatic logic op_is_known(input logic [2:0] op);
      return op <= CACHE_OP_REFILL;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   logic accept;
   logic pop;
   logic push;

   logic                     rc_ready_q;
   logic [OCC_W-1:0]         occ_q;
   logic [OCC_W-1:0]         occ_next;

   logic                     s1_valid;
   logic [2:0]               s1_op;
   logic [WAY_W+SET_W-1:0]   s1_addr;
   logic [WBUF_W-1:0]        s1_wbuf_id;
   logic [DATA_W-1:0]        s1_refill;
   logic [2:0]               s1_ch;
   logic [ROB_W-1:0]         s1_rob;
   logic [DATA_W-1:0]        merge_data;

   logic                     dl_valid  [SRAM_LAT];
   logic                     dl_load   [SRAM_LAT];
   logic [2:0]               dl_ch     [SRAM_LAT];
   logic [ROB_W-1:0]         dl_rob    [SRAM_LAT];
   logic [DATA_W-1:0]        dl_refill [SRAM_LAT];

   logic [2:0]               fifo_ch   [RSP_DEPTH];
   logic [ROB_W-1:0]         fifo_rob  [RSP_DEPTH];
   logic [DATA_W-1:0]        fifo_data [RSP_DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [OCC_W-1:0]         fifo_cnt;

   assign rc_ready   = rc_ready_q;
   assign accept     = rc_valid & rc_ready_q;
   assign wbuf_rd_en = accept & op_is_store(rc_op);
   assign wbuf_rd_id = rc_wbuf_id;

   assign rsp_valid           = (fifo_cnt != '0);
   assign pop                 = rsp_valid & rsp_ready;
   assign push                = dl_valid[SRAM_LAT-1];
   assign rsp_channel_1hot_id = fifo_ch[rd_ptr];
   assign rsp_rob_id          = fifo_rob[rd_ptr];
   assign rsp_data            = fifo_data[rd_ptr];

   // Credit covers responses both queued and still travelling down the delay line,
   // so a push can never find the FIFO full.
   assign occ_next = occ_q + OCC_W'(accept & op_is_rsp(rc_op)) - OCC_W'(pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q      <= '0;
         rc_ready_q <= 1'b0;
      end else begin
         occ_q      <= occ_next;
         rc_ready_q <= (occ_next < OCC_W'(RSP_DEPTH));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_op      <= '0;
         s1_addr    <= '0;
         s1_wbuf_id <= '0;
         s1_refill  <= '0;
         s1_ch      <= '0;
         s1_rob     <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_op      <= rc_op;
            s1_addr    <= {rc_way, rc_set};
            s1_wbuf_id <= rc_wbuf_id;
            s1_refill  <= rc_refill_data;
            s1_ch      <= rc_channel_1hot_id;
            s1_rob     <= rc_rob_id;
         end
      end
   end

   always_comb begin
      merge_data = s1_refill;
      for (int i = 0; i < BE_W; i++) begin
         if (wbuf_rd_be[i]) merge_data[8*i +: 8] = wbuf_rd_data[8*i +: 8];
      end
   end

   always_comb begin
      sram_en         = s1_valid & op_is_known(s1_op);
      sram_we         = sram_en & (s1_op != CACHE_OP_LOAD);
      sram_addr       = s1_addr;
      wbuf_free_valid = s1_valid & op_is_store(s1_op);
      wbuf_free_id    = s1_wbuf_id;
      case (s1_op)
         CACHE_OP_STORE:        sram_wdata = wbuf_rd_data;
         CACHE_OP_STORE_REFILL: sram_wdata = merge_data;
         default:               sram_wdata = s1_refill;
      endcase
   end

   // Delay line matches the SRAM read latency; the last stage lines up with sram_rdata.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SRAM_LAT; i++) begin
            dl_valid[i]  <= 1'b0;
            dl_load[i]   <= 1'b0;
            dl_ch[i]     <= '0;
            dl_rob[i]    <= '0;
            dl_refill[i] <= '0;
         end
      end else begin
         dl_valid[0]  <= s1_valid & op_is_rsp(s1_op);
         dl_load[0]   <= (s1_op == CACHE_OP_LOAD);
         dl_ch[0]     <= s1_ch;
         dl_rob[0]    <= s1_rob;
         dl_refill[0] <= s1_refill;
         for (int i = 1; i < SRAM_LAT; i++) begin
            dl_valid[i]  <= dl_valid[i-1];
            dl_load[i]   <= dl_load[i-1];
            dl_ch[i]     <= dl_ch[i-1];
            dl_rob[i]    <= dl_rob[i-1];
            dl_refill[i] <= dl_refill[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_ch[i]   <= '0;
            fifo_rob[i]  <= '0;
            fifo_data[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_ch[wr_ptr]   <= dl_ch[SRAM_LAT-1];
            fifo_rob[wr_ptr]  <= dl_rob[SRAM_LAT-1];
            fifo_data[wr_ptr] <= dl_load[SRAM_LAT-1] ? sram_rdata : dl_refill[SRAM_LAT-1];
            wr_ptr            <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         fifo_cnt <= fifo_cnt + OCC_W'(push) - OCC_W'(pop);
      end
   end

endmodule

// File: tb/tb_rc_sram_pipe.sv
// Bench for rc_sram_pipe: behavioural SRAM/write-buffer models plus an in-order
// response scoreboard, driven by directed cases and random traffic.
module tb_rc_sram_pipe;
   localparam int SET_W = 8, WAY_W = 2, ROB_W = 4, WBUF_W = 3, DATA_W = 128;
   localparam int SRAM_LAT = 2, RSP_DEPTH = 4;
   localparam int BE_W = DATA_W / 8, AW = WAY_W + SET_W;

   localparam logic [2:0] OP_LOAD = 3'd0, OP_STORE = 3'd1, OP_LOAD_REFILL = 3'd2;
   localparam logic [2:0] OP_STORE_REFILL = 3'd3, OP_REFILL = 4'd4;

   typedef logic [DATA_W-1:0] dw_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                rc_valid = 1'b0;
   logic                rc_ready;
   logic [2:0]          rc_channel_1hot_id = '0;
   logic [ROB_W-1:0]    rc_rob_id = '0;
   logic [2:0]          rc_op = '0;
   logic [SET_W-1:0]    rc_set = '0;
   logic [WAY_W-1:0]    rc_way = '0;
   logic [WBUF_W-1:0]   rc_wbuf_id = '0;
   logic [DATA_W-1:0]   rc_refill_data = '0;
   logic                wbuf_rd_en;
   logic [WBUF_W-1:0]   wbuf_rd_id;
   logic [DATA_W-1:0]   wbuf_rd_data;
   logic [BE_W-1:0]     wbuf_rd_be;
   logic                wbuf_free_valid;
   logic [WBUF_W-1:0]   wbuf_free_id;
   logic                sram_en;
   logic                sram_we;
   logic [AW-1:0]       sram_addr;
   logic [DATA_W-1:0]   sram_wdata;
   logic [DATA_W-1:0]   sram_rdata;
   logic                rsp_valid;
   logic                rsp_ready = 1'b0;
   logic [2:0]          rsp_channel_1hot_id;
   logic [ROB_W-1:0]    rsp_rob_id;
   logic [DATA_W-1:0]   rsp_data;

   rc_sram_pipe #(
      .SET_W(SET_W), .WAY_W(WAY_W), .ROB_W(ROB_W), .WBUF_W(WBUF_W),
      .DATA_W(DATA_W), .SRAM_LAT(SRAM_LAT), .RSP_DEPTH(RSP_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .rc_valid(rc_valid), .rc_ready(rc_ready),
      .rc_channel_1hot_id(rc_channel_1hot_id), .rc_rob_id(rc_rob_id), .rc_op(rc_op),
      .rc_set(rc_set), .rc_way(rc_way), .rc_wbuf_id(rc_wbuf_id), .rc_refill_data(rc_refill_data),
      .wbuf_rd_en(wbuf_rd_en), .wbuf_rd_id(wbuf_rd_id), .wbuf_rd_data(wbuf_rd_data), .wbuf_rd_be(wbuf_rd_be),
      .wbuf_free_valid(wbuf_free_valid), .wbuf_free_id(wbuf_free_id),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_channel_1hot_id(rsp_channel_1hot_id), .rsp_rob_id(rsp_rob_id), .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   task automatic check_val(input string tag, input dw_t got, input dw_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic dw_t rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- environment models ----------------
   dw_t             tb_mem    [1 << AW];
   dw_t             model_mem [1 << AW];
   dw_t             rd_pipe   [SRAM_LAT];
   dw_t             wb_data   [1 << WBUF_W];
   logic [BE_W-1:0] wb_be     [1 << WBUF_W];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sram_en && sram_we) tb_mem[sram_addr] = sram_wdata;
   end

   always @(posedge clk) begin
      rd_pipe[0] <= (sram_en && !sram_we) ? tb_mem[sram_addr] : rnd_line();
      for (int i = 1; i < SRAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      wbuf_rd_data <= wbuf_rd_en ? wb_data[wbuf_rd_id] : rnd_line();
      wbuf_rd_be   <= wbuf_rd_en ? wb_be[wbuf_rd_id] : BE_W'($urandom);
   end
   assign sram_rdata = rd_pipe[SRAM_LAT-1];

   // ---------------- reference model / scoreboard ----------------
   typedef struct {
      logic [2:0]       ch;
      logic [ROB_W-1:0] rob;
      dw_t              data;
      int               due;
   } rsp_t;

   rsp_t            rq[$];
   logic            mon_en = 1'b0;
   logic            pa_en = 1'b0, pa_we = 1'b0, pa_free = 1'b0;
   logic [AW-1:0]   pa_addr = '0;
   dw_t             pa_wdata = '0;
   logic [WBUF_W-1:0] pa_free_id = '0;

   always @(negedge clk) begin
      logic exp_ready, acc, exp_rv, is_store;
      logic [AW-1:0] a;
      dw_t wd;
      rsp_t e;
      if (mon_en) begin
         check_val("sram_en", dw_t'(sram_en), dw_t'(pa_en));
         check_val("sram_we", dw_t'(sram_we), dw_t'(pa_we));
         if (pa_en) check_val("sram_addr", dw_t'(sram_addr), dw_t'(pa_addr));
         if (pa_en && pa_we) check_val("sram_wdata", sram_wdata, pa_wdata);
         check_val("wbuf_free_valid", dw_t'(wbuf_free_valid), dw_t'(pa_free));
         if (pa_free) check_val("wbuf_free_id", dw_t'(wbuf_free_id), dw_t'(pa_free_id));

         exp_ready = (rq.size() < RSP_DEPTH);
         check_val("rc_ready", dw_t'(rc_ready), dw_t'(exp_ready));
         acc = rc_valid && exp_ready;

         exp_rv = (rq.size() > 0) && (rq[0].due <= cyc);
         check_val("rsp_valid", dw_t'(rsp_valid), dw_t'(exp_rv));
         if (exp_rv) begin
            check_val("rsp_ch", dw_t'(rsp_channel_1hot_id), dw_t'(rq[0].ch));
            check_val("rsp_rob", dw_t'(rsp_rob_id), dw_t'(rq[0].rob));
            check_val("rsp_data", rsp_data, rq[0].data);
            if (rsp_ready) void'(rq.pop_front());
         end

         is_store = (rc_op == OP_STORE) || (rc_op == OP_STORE_REFILL);
         check_val("wbuf_rd_en", dw_t'(wbuf_rd_en), dw_t'(acc && is_store));
         if (acc && is_store) check_val("wbuf_rd_id", dw_t'(wbuf_rd_id), dw_t'(rc_wbuf_id));

         pa_en = 1'b0; pa_we = 1'b0; pa_free = 1'b0;
         if (acc) begin
            a = {rc_way, rc_set};
            wd = rc_refill_data;
            pa_addr = a;
            pa_free = is_store;
            pa_free_id = rc_wbuf_id;
            e.ch = rc_channel_1hot_id; e.rob = rc_rob_id; e.due = cyc + 2 + SRAM_LAT;
            case (rc_op)
               OP_LOAD: begin
                  pa_en = 1'b1;
                  e.data = model_mem[a];
                  rq.push_back(e);
               end
               OP_STORE: wd = wb_data[rc_wbuf_id];
               OP_STORE_REFILL:
                  for (int b = 0; b < BE_W; b++)
                     if (wb_be[rc_wbuf_id][b]) wd[8*b +: 8] = wb_data[rc_wbuf_id][8*b +: 8];
               OP_LOAD_REFILL: begin
                  e.data = rc_refill_data;
                  rq.push_back(e);
               end
               default: ;
            endcase
            if (rc_op != OP_LOAD && rc_op <= OP_REFILL) begin
               pa_en = 1'b1; pa_we = 1'b1; pa_wdata = wd;
               model_mem[a] = wd;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [2:0] ch, input logic [ROB_W-1:0] rob,
                       input logic [WAY_W-1:0] way, input logic [SET_W-1:0] set,
                       input logic [WBUF_W-1:0] wid, input dw_t refill);
      int n = 0;
      rc_valid = 1'b1; rc_op = op; rc_channel_1hot_id = ch; rc_rob_id = rob;
      rc_way = way; rc_set = set; rc_wbuf_id = wid; rc_refill_data = refill;
      @(negedge clk);
      while (!rc_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      check_val("send_accept", dw_t'(rc_ready), dw_t'(1'b1));
      @(posedge clk); #1;
      rc_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      rc_valid = 1'b0;
      rsp_ready = 1'b1;
      while (rq.size() != 0 && n < 200) begin
         n++;
         @(posedge clk); #1;
      end
      check_val("drain_done", dw_t'(rq.size()), dw_t'(0));
      idle(3);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_sram_en"}, dw_t'(sram_en), '0);
      check_val({tag, "_sram_we"}, dw_t'(sram_we), '0);
      check_val({tag, "_wbuf_rd_en"}, dw_t'(wbuf_rd_en), '0);
      check_val({tag, "_wbuf_free"}, dw_t'(wbuf_free_valid), '0);
      check_val({tag, "_rsp_valid"}, dw_t'(rsp_valid), '0);
      check_val({tag, "_rc_ready"}, dw_t'(rc_ready), '0);
   endtask

   task automatic apply_reset();
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst");
      idle(3);
      rq.delete();
      pa_en = 1'b0; pa_we = 1'b0; pa_free = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      check_val("rc_ready_after_rst", dw_t'(rc_ready), dw_t'(1'b1));
      mon_en = 1'b1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         model_mem[i] = rnd_line();
         tb_mem[i] = model_mem[i];
      end
      for (int i = 0; i < (1 << WBUF_W); i++) begin
         wb_data[i] = rnd_line();
         wb_be[i] = BE_W'($urandom);
      end
      @(posedge clk); #1;
      apply_reset();
      rsp_ready = 1'b1;

      // single load: way1 set5 rob3 channel 001
      send(OP_LOAD, 3'b001, 4'd3, 2'd1, 8'd5, '0, rnd_line());
      idle(8);

      // full-line store from wbuf entry 2, then read it back
      send(OP_STORE, 3'b010, 4'd0, 2'd2, 8'h33, 3'd2, rnd_line());
      send(OP_LOAD, 3'b010, 4'd1, 2'd2, 8'h33, '0, rnd_line());
      idle(8);

      // byte-merged store refill, then read back
      wb_be[5] = 16'h000F;
      send(OP_STORE_REFILL, 3'b100, 4'd2, 2'd3, 8'h7A, 3'd5, rnd_line());
      send(OP_LOAD, 3'b100, 4'd4, 2'd3, 8'h7A, '0, rnd_line());
      idle(8);

      // credit back-pressure: 4 loads fill the response budget
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(OP_LOAD, 3'b001, ROB_W'(i), 2'(i), 8'(i + 10), '0, rnd_line());
      rc_valid = 1'b1; rc_op = OP_LOAD; rc_rob_id = 4'd4; rc_channel_1hot_id = 3'b001;
      rc_way = 2'd0; rc_set = 8'd20;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_val("fifth_held", dw_t'(rc_ready), '0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      send(OP_LOAD, 3'b001, 4'd4, 2'd0, 8'd20, '0, rnd_line());
      drain();

      // LOAD_REFILL followed by LOAD keeps accept order
      send(OP_LOAD_REFILL, 3'b010, 4'd7, 2'd1, 8'd99, '0, rnd_line());
      send(OP_LOAD, 3'b100, 4'd8, 2'd1, 8'd99, '0, rnd_line());
      drain();

      // unknown ops: no access, no response
      send(3'd6, 3'b001, 4'd9, 2'd0, 8'd1, '0, rnd_line());
      send(3'd7, 3'b001, 4'd9, 2'd0, 8'd2, '0, rnd_line());
      idle(6);

      // reset with three loads in flight
      for (int i = 0; i < 3; i++) send(OP_LOAD, 3'b001, ROB_W'(i), 2'd0, 8'(i), '0, rnd_line());
      apply_reset();
      rsp_ready = 1'b1;
      idle(10);

      // random traffic with random response back-pressure
      for (int i = 0; i < (1 << WBUF_W); i++) begin
         wb_data[i] = rnd_line();
         wb_be[i] = BE_W'($urandom);
      end
      for (int i = 0; i < 800; i++) begin
         rc_valid = ($urandom_range(0, 3) != 0);
         rc_op = 3'($urandom_range(0, 7));
         rc_channel_1hot_id = 3'(1 << $urandom_range(0, 2));
         rc_rob_id = ROB_W'($urandom);
         rc_way = WAY_W'($urandom_range(0, 1));
         rc_set = SET_W'($urandom_range(0, 7));
         rc_wbuf_id = WBUF_W'($urandom);
         rc_refill_data = rnd_line();
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
